// File: rtl/lab3_cache_refill_unit.sv
// lab3_cache_refill_unit: miss handler doing optional dirty-victim writeback, word-serial line fetch and line refill
// Ports: clk, reset (async, active-high); miss_val/miss_rdy/miss_addr/miss_dirty/victim_addr/victim_data from M1
//   (miss_rdy low stalls M0/M1); memreq_*/memresp_* single-outstanding word memory port;
//   refill_val/refill_rdy/refill_addr/refill_data line to the data array; busy = not idle.
// Optional macro LAB3_CACHE_REFILL_PERF_EN adds saturating perf_num_misses / perf_num_writebacks.
module lab3_cache_refill_unit #(
  parameter int p_addr_nbits = 32,
  parameter int p_word_nbits = 32,
  parameter int p_line_words = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 miss_val,
  output logic                                 miss_rdy,
  input  logic [p_addr_nbits-1:0]              miss_addr,
  input  logic                                 miss_dirty,
  input  logic [p_addr_nbits-1:0]              victim_addr,
  input  logic [p_line_words*p_word_nbits-1:0] victim_data,
  output logic                                 memreq_val,
  input  logic                                 memreq_rdy,
  output logic                                 memreq_type,
  output logic [p_addr_nbits-1:0]              memreq_addr,
  output logic [p_word_nbits-1:0]              memreq_data,
  input  logic                                 memresp_val,
  output logic                                 memresp_rdy,
  input  logic [p_word_nbits-1:0]              memresp_data,
  output logic                                 refill_val,
  input  logic                                 refill_rdy,
  output logic [p_addr_nbits-1:0]              refill_addr,
  output logic [p_line_words*p_word_nbits-1:0] refill_data,
`ifdef LAB3_CACHE_REFILL_PERF_EN
  output logic [31:0]                          perf_num_misses,
  output logic [31:0]                          perf_num_writebacks,
`endif
  output logic                                 busy
);
  localparam int w = p_word_nbits;
  localparam int c = $clog2(p_line_words);
  localparam logic [p_addr_nbits-1:0] word_bytes = p_addr_nbits'(p_word_nbits / 8);
  typedef enum logic [2:0] {IDLE, WB_REQ, WB_RESP, RD_REQ, RD_RESP, DONE} state_t;
  state_t state;
  logic [c-1:0] cnt, nxt;
  logic last;
  logic [p_line_words*p_word_nbits-1:0] vdata;
  assign nxt = cnt + 1'b1;
  assign last = cnt == c'(p_line_words - 1);
  // refill_addr doubles as the captured miss address; memreq_addr walks forward one word per request
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      vdata       <= '0;
      miss_rdy    <= 1'b1;
      busy        <= 1'b0;
      memreq_val  <= 1'b0;
      memreq_type <= 1'b0;
      memreq_addr <= '0;
      memreq_data <= '0;
      memresp_rdy <= 1'b0;
      refill_val  <= 1'b0;
      refill_addr <= '0;
      refill_data <= '0;
    end else case (state)
      IDLE: if (miss_val) begin
        refill_addr <= miss_addr;
        vdata       <= victim_data;
        cnt         <= '0;
        miss_rdy    <= 1'b0;
        busy        <= 1'b1;
        memreq_val  <= 1'b1;
        memreq_type <= miss_dirty;
        memreq_addr <= miss_dirty ? victim_addr : miss_addr;
        memreq_data <= miss_dirty ? victim_data[w-1:0] : '0;
        state       <= miss_dirty ? WB_REQ : RD_REQ;
      end
      WB_REQ, RD_REQ: if (memreq_rdy) begin
        memreq_val  <= 1'b0;
        memresp_rdy <= 1'b1;
        state       <= state == WB_REQ ? WB_RESP : RD_RESP;
      end
      WB_RESP: if (memresp_val) begin
        memresp_rdy <= 1'b0;
        memreq_val  <= 1'b1;
        cnt         <= nxt;
        memreq_type <= !last;
        memreq_addr <= last ? refill_addr : memreq_addr + word_bytes;
        memreq_data <= last ? '0 : vdata[nxt*w +: w];
        state       <= last ? RD_REQ : WB_REQ;
      end
      RD_RESP: if (memresp_val) begin
        refill_data[cnt*w +: w] <= memresp_data;
        memresp_rdy <= 1'b0;
        cnt         <= nxt;
        memreq_val  <= !last;
        refill_val  <= last;
        memreq_addr <= last ? memreq_addr : memreq_addr + word_bytes;
        state       <= last ? DONE : RD_REQ;
      end
      DONE: if (refill_rdy) begin
        refill_val <= 1'b0;
        busy       <= 1'b0;
        miss_rdy   <= 1'b1;
        state      <= IDLE;
      end
      default: state <= IDLE;
    endcase
`ifdef LAB3_CACHE_REFILL_PERF_EN
  // adding the inverted all-ones flag makes each counter stick at its maximum
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_num_misses     <= '0;
      perf_num_writebacks <= '0;
    end else if (miss_val && miss_rdy) begin
      perf_num_misses     <= perf_num_misses + {31'd0, ~&perf_num_misses};
      perf_num_writebacks <= perf_num_writebacks + {31'd0, miss_dirty & ~&perf_num_writebacks};
    end
`endif
endmodule

// File: tb/tb_lab3_cache_refill_unit.sv
// tb_lab3_cache_refill_unit: randomized bench for lab3_cache_refill_unit against a transaction-level model
module tb_lab3_cache_refill_unit;
  logic clk, reset;
  logic miss_val, miss_rdy, miss_dirty;
  logic [31:0] miss_addr, victim_addr;
  logic [127:0] victim_data;
  logic memreq_val, memreq_rdy, memreq_type;
  logic [31:0] memreq_addr, memreq_data;
  logic memresp_val, memresp_rdy;
  logic [31:0] memresp_data;
  logic refill_val, refill_rdy;
  logic [31:0] refill_addr;
  logic [127:0] refill_data;
  logic busy;
`ifdef LAB3_CACHE_REFILL_PERF_EN
  logic [31:0] perf_num_misses, perf_num_writebacks;
`endif

  lab3_cache_refill_unit dut (
    .clk(clk), .reset(reset),
    .miss_val(miss_val), .miss_rdy(miss_rdy), .miss_addr(miss_addr), .miss_dirty(miss_dirty),
    .victim_addr(victim_addr), .victim_data(victim_data),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
    .memreq_addr(memreq_addr), .memreq_data(memreq_data),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_data(memresp_data),
    .refill_val(refill_val), .refill_rdy(refill_rdy), .refill_addr(refill_addr), .refill_data(refill_data),
`ifdef LAB3_CACHE_REFILL_PERF_EN
    .perf_num_misses(perf_num_misses), .perf_num_writebacks(perf_num_writebacks),
`endif
    .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct packed {logic t; logic [31:0] a; logic [31:0] d;} req_t;
  req_t exp_req[$];
  logic [127:0] exp_line[$];
  logic [31:0] exp_addr[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int n_chk, n_fail, cyc, lat_start, exp_lat, last_ref_cyc;
  int req_pct, ref_pct, dly_max, req_hold, ref_hold, ref_high, n_miss, n_wb, pend_cnt;
  bit pend, inflight, ref_seen, lat_chk, gap_chk, miss_fired, prev_req_stall, prev_ref_stall;
  logic [31:0] pend_data, hold_addr, last_req_addr;
  logic [65:0] prev_req;
  logic [160:0] prev_ref;
  logic [127:0] last_line, vd;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic reset_bench();
    pend = 0; inflight = 0; ref_seen = 1; prev_req_stall = 0; prev_ref_stall = 0;
    exp_req.delete(); exp_line.delete(); exp_addr.delete();
    n_miss = 0; n_wb = 0; req_hold = 0; ref_hold = 0; memresp_val = 0;
  endtask

  // one cycle: drive memory/refill side at the negedge, score fires that happen at the next posedge
  task automatic tick();
    req_t e;
    logic [31:0] a;
    logic [127:0] line;
    check("busy_state", {miss_rdy, busy}, {!inflight, inflight});
    memresp_val = pend && pend_cnt == 0;
    memresp_data = memresp_val ? pend_data : $urandom;
    if (memresp_val && memresp_rdy) pend = 0;
    else if (pend && pend_cnt > 0) pend_cnt--;
    if (prev_req_stall) check("req_stable", {memreq_val, memreq_type, memreq_addr, memreq_data}, prev_req);
    if (req_hold > 0 && memreq_val && memreq_addr == hold_addr) begin
      memreq_rdy = 0;
      req_hold--;
    end else memreq_rdy = $urandom_range(99) < req_pct;
    prev_req_stall = memreq_val && !memreq_rdy;
    prev_req = {1'b1, memreq_type, memreq_addr, memreq_data};
    if (memreq_val && memreq_rdy) begin
      check("one_outstanding", pend, 0);
      check("req_expected", exp_req.size() != 0, 1);
      if (exp_req.size() != 0) begin
        e = exp_req.pop_front();
        check("req_type", memreq_type, e.t);
        check("req_addr", memreq_addr, e.a);
        check("req_data", memreq_data, e.d);
      end
      last_req_addr = memreq_addr;
      if (memreq_type) begin
        mem[memreq_addr] = memreq_data;
        pend_data = $urandom;
      end else pend_data = mem_rd(memreq_addr);
      pend = 1;
      pend_cnt = int'($urandom_range(dly_max));
    end
    if (prev_ref_stall) check("refill_stable", {refill_val, refill_addr, refill_data}, prev_ref);
    if (ref_hold > 0 && refill_val) begin
      refill_rdy = 0;
      ref_hold--;
    end else refill_rdy = $urandom_range(99) < ref_pct;
    prev_ref_stall = refill_val && !refill_rdy;
    prev_ref = {1'b1, refill_addr, refill_data};
    if (refill_val) ref_high++;
    if (refill_val && !ref_seen) begin
      ref_seen = 1;
      if (lat_chk) check("refill_latency", cyc - lat_start, exp_lat);
    end
    if (refill_val && refill_rdy) begin
      check("refill_expected", exp_line.size() != 0, 1);
      if (exp_line.size() != 0) begin
        check("refill_addr", refill_addr, exp_addr.pop_front());
        check("refill_data", refill_data, exp_line.pop_front());
      end
      last_line = refill_data;
      inflight = 0;
      last_ref_cyc = cyc;
    end
    if (miss_val && miss_rdy) begin
      check("miss_while_busy", inflight, 0);
      if (gap_chk && last_ref_cyc >= 0) check("miss_gap", cyc - last_ref_cyc, 1);
      line = '0;
      if (miss_dirty)
        for (int i = 0; i < 4; i++) begin
          a = victim_addr + 32'(4 * i);
          exp_req.push_back(req_t'{1'b1, a, victim_data[32*i +: 32]});
          ref_mem[a] = victim_data[32*i +: 32];
        end
      for (int i = 0; i < 4; i++) begin
        a = miss_addr + 32'(4 * i);
        exp_req.push_back(req_t'{1'b0, a, 32'd0});
        line[32*i +: 32] = ref_rd(a);
      end
      exp_line.push_back(line);
      exp_addr.push_back(miss_addr);
      inflight = 1; ref_seen = 0; lat_start = cyc;
      exp_lat = miss_dirty ? 4 * 4 + 1 : 2 * 4 + 1;
      n_miss++; n_wb += int'(miss_dirty); miss_fired = 1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && inflight; i++) tick();
    check("refill_done", inflight, 0);
  endtask

  task automatic do_miss(input logic [31:0] ma, input logic d, input logic [31:0] va, input logic [127:0] vdat);
    miss_val = 1; miss_addr = ma; miss_dirty = d; victim_addr = va; victim_data = vdat; miss_fired = 0;
    for (int i = 0; i < 200 && !miss_fired; i++) tick();
    check("miss_accepted", miss_fired, 1);
    miss_val = 0; miss_addr = $urandom; miss_dirty = 1'($urandom); victim_addr = $urandom;
    victim_data = {$urandom, $urandom, $urandom, $urandom};
    wait_idle();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; last_ref_cyc = -1; gap_chk = 0; lat_chk = 0; ref_high = 0;
    last_req_addr = 0; last_line = 0;
    reset = 1; miss_val = 0; miss_addr = 0; miss_dirty = 0; victim_addr = 0; victim_data = 0;
    memreq_rdy = 0; memresp_data = 0; refill_rdy = 0;
    reset_bench();
    repeat (3) @(negedge clk);
    check("rst_ctrl", {miss_rdy, busy, memreq_val, memresp_rdy, refill_val, memreq_type}, 6'b100000);
    check("rst_req", {memreq_addr, memreq_data}, 0);
    check("rst_refill", {refill_addr, refill_data}, 0);
`ifdef LAB3_CACHE_REFILL_PERF_EN
    check("rst_perf", {perf_num_misses, perf_num_writebacks}, 0);
`endif
    reset = 0;
    req_pct = 100; ref_pct = 100; dly_max = 0; lat_chk = 1;
    for (int i = 0; i < 4; i++) begin
      mem[32'(32'h1000 + 4 * i)] = 32'(32'hA0 + i);
      ref_mem[32'(32'h1000 + 4 * i)] = 32'(32'hA0 + i);
    end
    do_miss(32'h1000, 0, 32'h0, 128'h0);
    check("t1_line", last_line, 128'h000000A3_000000A2_000000A1_000000A0);
    do_miss(32'h3000, 1, 32'h2000, 128'h00000014_00000013_00000012_00000011);
    check("t2_wb_mem", {mem[32'h200C], mem[32'h2000]}, {32'h14, 32'h11});
`ifdef LAB3_CACHE_REFILL_PERF_EN
    check("t2_perf", {perf_num_misses, perf_num_writebacks}, {32'd2, 32'd1});
`endif
    lat_chk = 0; req_hold = 3; hold_addr = 32'h5008; ref_hold = 5; ref_high = 0;
    do_miss(32'h5000, 0, 32'h0, 128'h0);
    check("t3_req_stall_used", req_hold, 0);
    check("t3_refill_held", ref_high, 6);
    check("t3_idle_next", {miss_rdy, busy}, 2'b10);
    gap_chk = 1; last_ref_cyc = -1;
    miss_val = 1; miss_addr = 32'h1000; miss_dirty = 0; miss_fired = 0;
    for (int i = 0; i < 50 && !miss_fired; i++) tick();
    miss_addr = 32'h4000; miss_fired = 0;
    for (int i = 0; i < 100 && !miss_fired; i++) tick();
    check("t4_second_accept", miss_fired, 1);
    miss_val = 0;
    wait_idle();
    gap_chk = 0;
    miss_val = 1; miss_addr = 32'h1000; miss_dirty = 0; miss_fired = 0; last_req_addr = 0;
    for (int i = 0; i < 50 && !miss_fired; i++) tick();
    miss_val = 0;
    for (int i = 0; i < 20 && last_req_addr != 32'h1004; i++) tick();
    check("t5_reached_word1", last_req_addr, 32'h1004);
    reset = 1;
    reset_bench();
    #1;
    check("t5_async_reset", {memreq_val, refill_val, miss_rdy, busy, memresp_rdy}, 5'b00100);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_quiet", {memreq_val, refill_val}, 2'b00);
    end
`ifdef LAB3_CACHE_REFILL_PERF_EN
    check("t5_perf_cleared", {perf_num_misses, perf_num_writebacks}, 0);
`endif
    lat_chk = 1;
    do_miss(32'h1000, 0, 32'h0, 128'h0);
    check("t5_line", last_line, 128'h000000A3_000000A2_000000A1_000000A0);
    vd = {$urandom, $urandom, $urandom, $urandom};
    do_miss(32'hFFFFFFF0, 1, 32'hFFFFFFF0, vd);
    check("t6_wrap_line", last_line, vd);
    lat_chk = 0; req_pct = 70; ref_pct = 60; dly_max = 3;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(3)) begin
        miss_addr = $urandom; miss_dirty = 1'($urandom);
        tick();
      end
      vd = {$urandom, $urandom, $urandom, $urandom};
      do_miss(k % 8 == 7 ? 32'hFFFFFFF0 : 32'h1000 + 32'($urandom_range(7) * 16), 1'($urandom_range(1)),
              k % 5 == 4 ? 32'hFFFFFFF0 : 32'h1000 + 32'($urandom_range(7) * 16), vd);
    end
    check("queues_drained", exp_req.size() + exp_line.size(), 0);
`ifdef LAB3_CACHE_REFILL_PERF_EN
    check("perf_final", {perf_num_misses, perf_num_writebacks}, {n_miss, n_wb});
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
